// File: rtl/nibble_serial_adder.sv
// Serial multi-word adder: one 4-bit add-with-carry per clock, least-significant nibble first.
// The start/busy/done handshake presents the final sum and carry only after the last nibble.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   Cout
);

  localparam int W     = 4 * NIBBLES;
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_sr_q, a_sr_d;
  logic [W-1:0]     b_sr_q, b_sr_d;
  logic [W-1:0]     part_q, part_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [4:0]       nib_sum;
  logic [W-1:0]     part_shift;

  assign nib_sum = {1'b0, a_sr_q[3:0]} + {1'b0, b_sr_q[3:0]} + {4'b0000, carry_q};

  // New nibble enters at the top so after NIBBLES shifts the word is aligned.
  generate
    if (NIBBLES == 1) begin : g_single
      assign part_shift = nib_sum[3:0];
    end else begin : g_multi
      assign part_shift = {nib_sum[3:0], part_q[W-1:4]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      part_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      part_q  <= part_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    part_d  = part_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = done_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          part_d  = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        carry_d = nib_sum[4];
        a_sr_d  = a_sr_q >> 4;
        b_sr_d  = b_sr_q >> 4;
        part_d  = part_shift;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          sum_d   = part_shift;
          cout_d  = nib_sum[4];
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: a 4-nibble instance and a 1-nibble instance
// driven on a shared clock/reset, each result checked against hand-computed values.
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst;

  logic        start4;
  logic [15:0] a4, b4;
  logic        busy4, done4, cout4;
  logic [15:0] sum4;

  logic        start1;
  logic [3:0]  a1, b1;
  logic        busy1, done1, cout1;
  logic [3:0]  sum1;

  int checks;
  int errors;

  nibble_serial_adder #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .Cout(cout4)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .Cout(cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation on the 4-nibble DUT and follow it to completion.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] es, input logic ec);
    logic [15:0] prev;
    int          nbusy;
    bit          held;
    prev   = sum4;
    held   = 1'b1;
    nbusy  = 0;
    a4     = av;
    b4     = bv;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    a4     = ~av;
    b4     = 16'h5A5A;
    while (busy4 && nbusy < 20) begin
      if (sum4 !== prev || done4 !== 1'b0) held = 1'b0;
      nbusy++;
      tick();
    end
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'd4);
    check({tag, "_sum_held"}, 32'(held), 32'd1);
    check({tag, "_done"}, 32'(done4), 32'd1);
    check({tag, "_sum"}, 32'(sum4), 32'(es));
    check({tag, "_cout"}, 32'(cout4), 32'(ec));
    tick();
    check({tag, "_done_fall"}, 32'(done4), 32'd0);
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    tick();
    tick();
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_done4", 32'(done4), 32'd0);
    check("rst_sum4", 32'(sum4), 32'd0);
    check("rst_cout4", 32'(cout4), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    rst = 1'b0;
    tick();

    // Basic add, then full carry ripple.
    run_op("t1", 16'h1234, 16'h4321, 16'h5555, 1'b0);
    run_op("t2", 16'hFFFF, 16'h0001, 16'h0000, 1'b1);

    // Start while busy must be ignored.
    a4 = 16'hFFFF; b4 = 16'hFFFF; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    a4 = 16'h0001; b4 = 16'h0001; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 20) begin n++; tick(); end
    check("t3_done", 32'(done4), 32'd1);
    check("t3_sum", 32'(sum4), 32'hFFFE);
    check("t3_cout", 32'(cout4), 32'd1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done4 || busy4) n++;
    end
    check("t3_no_second_op", 32'(n), 32'd0);

    // Reset mid-operation.
    a4 = 16'h8000; b4 = 16'h8000; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("t4_rst_busy", 32'(busy4), 32'd0);
    check("t4_rst_done", 32'(done4), 32'd0);
    check("t4_rst_sum", 32'(sum4), 32'd0);
    check("t4_rst_cout", 32'(cout4), 32'd0);
    tick();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done4 || busy4) n++;
    end
    check("t4_no_done", 32'(n), 32'd0);
    run_op("t4b", 16'h00FF, 16'h0001, 16'h0100, 1'b0);

    // start held high: one operation every 6 cycles.
    a4 = 16'h0F0F; b4 = 16'h0101; start4 = 1'b1;
    tick();
    a4 = 16'hFFFF;
    n = 0;
    while (!done4 && n < 20) begin n++; tick(); end
    check("t5_first_latency", 32'(n), 32'd4);
    check("t5_first_sum", 32'(sum4), 32'h1010);
    a4 = 16'h0F0F;
    n = 0;
    do begin
      n++;
      tick();
      if (n == 2) a4 = 16'hFFFF;
    end while (!done4 && n < 20);
    check("t5_period", 32'(n), 32'd6);
    check("t5_second_sum", 32'(sum4), 32'h1010);
    check("t5_second_cout", 32'(cout4), 32'd0);
    start4 = 1'b0;
    tick();

    // Single-nibble instance.
    a1 = 4'hF; b1 = 4'h1; start1 = 1'b1;
    tick();
    start1 = 1'b0; a1 = 4'h0; b1 = 4'h0;
    check("n1_busy", 32'(busy1), 32'd1);
    check("n1_done_early", 32'(done1), 32'd0);
    tick();
    check("n1_busy_fall", 32'(busy1), 32'd0);
    check("n1_done", 32'(done1), 32'd1);
    check("n1_sum", 32'(sum1), 32'h0);
    check("n1_cout", 32'(cout1), 32'd1);
    tick();
    check("n1_done_fall", 32'(done1), 32'd0);
    a1 = 4'h3; b1 = 4'h4; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    check("n1b_sum", 32'(sum1), 32'h7);
    check("n1b_cout", 32'(cout1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
